// File: rtl/fixed_lut_activation_if.sv
// Stream and table-load signals of the LUT activation block, bundled with
// a slave view for the block and a master view for whoever drives it.
interface fixed_lut_activation_if #(
  parameter int unsigned NUM        = 4,
  parameter int unsigned IN_W       = 8,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [NUM-1:0][IN_W-1:0]  data_in_0;
  logic                      data_in_0_valid;
  logic                      data_in_0_ready;
  logic [NUM-1:0][OUT_W-1:0] data_out_0;
  logic                      data_out_0_valid;
  logic                      data_out_0_ready;
  logic                      tbl_load_start;
  logic                      tbl_wr_en;
  logic [ADDR_WIDTH-1:0]     tbl_wr_addr;
  logic [OUT_W-1:0]          tbl_wr_data;
  logic                      tbl_load_done;
  logic                      tbl_ready;

  modport slave (
    input  data_in_0, data_in_0_valid, data_out_0_ready,
    input  tbl_load_start, tbl_wr_en, tbl_wr_addr, tbl_wr_data, tbl_load_done,
    output data_in_0_ready, data_out_0, data_out_0_valid, tbl_ready
  );

  modport master (
    output data_in_0, data_in_0_valid, data_out_0_ready,
    output tbl_load_start, tbl_wr_en, tbl_wr_addr, tbl_wr_data, tbl_load_done,
    input  data_in_0_ready, data_out_0, data_out_0_valid, tbl_ready
  );
endinterface

// File: rtl/fixed_lut_activation.sv
// Table-driven elementwise activation: per-lane saturation into the table
// address range, then a registered lookup, with a runtime-loadable table.
module fixed_lut_activation #(
  parameter int unsigned DATA_IN_0_PRECISION_0  = 8,
  parameter int unsigned DATA_IN_0_PARALLELISM  = 4,
  parameter int unsigned ADDR_WIDTH             = 8,
  parameter int unsigned DATA_OUT_0_PRECISION_0 = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  fixed_lut_activation_if.slave  io
);
  localparam int unsigned NUM   = DATA_IN_0_PARALLELISM;
  localparam int unsigned IN_W  = DATA_IN_0_PRECISION_0;
  localparam int unsigned OUT_W = DATA_OUT_0_PRECISION_0;
  localparam int unsigned A     = ADDR_WIDTH;
  localparam int unsigned DEPTH = 1 << A;
  localparam int unsigned SAT_W = IN_W - A + 1;
  localparam logic [A-1:0] MIN_ADDR = A'(1) << (A - 1);
  localparam logic [A-1:0] MAX_ADDR = ~MIN_ADDR;

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DRAIN} state_e;

  state_e                     state_q, state_d;
  logic [OUT_W-1:0]           tbl_q [DEPTH];
  logic                       s1_valid_q;
  logic [NUM-1:0][A-1:0]      s1_addr_q;
  logic                       out_valid_q;
  logic [NUM-1:0][OUT_W-1:0]  out_data_q;
  logic [NUM-1:0][A-1:0]      clamp_addr;
  logic [NUM-1:0][OUT_W-1:0]  lut_rd;
  logic                       adv;
  logic                       accept;

  assign adv                 = !out_valid_q || io.data_out_0_ready;
  assign io.data_in_0_ready  = adv && (state_q == ST_RUN) && !io.tbl_load_start;
  assign accept              = io.data_in_0_valid && io.data_in_0_ready;
  assign io.tbl_ready        = (state_q == ST_RUN);
  assign io.data_out_0       = out_data_q;
  assign io.data_out_0_valid = out_valid_q;

  // Load / run / drain sequencing; DRAIN lets in-flight beats finish on the old table.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (io.tbl_load_done)          state_d = ST_RUN;
      ST_RUN:   if (io.tbl_load_start)         state_d = ST_DRAIN;
      ST_DRAIN: if (!s1_valid_q && !out_valid_q) state_d = ST_LOAD;
      default:                                 state_d = ST_LOAD;
    endcase
  end

  // In range when every bit above the address MSB matches the sign bit.
  always_comb begin
    clamp_addr = '0;
    for (int i = 0; i < int'(NUM); i++) begin
      if (io.data_in_0[i][IN_W-1:A-1] == {SAT_W{io.data_in_0[i][IN_W-1]}})
        clamp_addr[i] = io.data_in_0[i][A-1:0];
      else if (io.data_in_0[i][IN_W-1])
        clamp_addr[i] = MIN_ADDR;
      else
        clamp_addr[i] = MAX_ADDR;
    end
  end

  always_comb begin
    lut_rd = '0;
    for (int i = 0; i < int'(NUM); i++) begin
      lut_rd[i] = tbl_q[s1_addr_q[i]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (adv) begin
        s1_valid_q  <= accept;
        out_valid_q <= s1_valid_q;
        if (accept)     s1_addr_q  <= clamp_addr;
        if (s1_valid_q) out_data_q <= lut_rd;
      end
    end
  end

  // Table storage survives reset; writes land only while loading.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && io.tbl_wr_en) begin
      tbl_q[io.tbl_wr_addr] <= io.tbl_wr_data;
    end
  end
endmodule
